if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 1024: instruction memory size in bytes, used for range checking.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port imem_pc  output  32  byte address to instruction memory; equals the internal PC register.
REQ-006 SHALL have port imem_instr  input  32  combinational little-endian word returned for imem_pc.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc  input  32  target byte address for the redirect.
REQ-009 SHALL have port id_ready  input  1  decode accepts the IF/ID word this cycle.
REQ-010 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 SHALL have port id_pc  output  32  address of the held instruction.
REQ-012 SHALL have port id_instr  output  32  held instruction word.
REQ-013 SHALL have port id_pc_plus4  output  32  id_pc + 4, registered with the word.
REQ-014 SHALL have port fetch_fault  output  1  sticky misaligned or out-of-range fetch indication.
REQ-015 SHALL have port fetch_count  output  32  count of instructions handed to decode.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FAULT.
REQ-017 BOOT SHALL last exactly one cycle after rst_n deasserts, with no fetch and no handshake, then go to RUN.
REQ-018 In RUN, advance SHALL be (!id_valid || id_ready).
REQ-019 On advance with a legal PC and no redirect: id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
REQ-020 While id_valid && !id_ready (stall), pc and all id_* outputs SHALL hold.
REQ-021 redirect_valid SHALL have priority over advance and stall: pc<=redirect_pc, id_valid<=0 (flush) next cycle, regardless of id_ready.
REQ-022 A redirect in BOOT SHALL be ignored; a redirect in FAULT SHALL be ignored.
REQ-023 A PC SHALL be legal iff pc[1:0]==0 and pc <= IMEM_SIZE-4 (unsigned 32-bit compare).
REQ-024 In RUN with an illegal PC, no redirect and advance true: id_valid<=0, fetch_fault<=1, state<=FAULT; pc SHALL hold the offending address.
REQ-025 With an illegal PC while stalled: hold; the fault SHALL be taken on the first cycle advance becomes true.
REQ-026 In FAULT: no fetch, id_valid=0, fetch_fault=1; exit only by reset.
REQ-027 fetch_count SHALL increment by 1 on each cycle with id_valid && id_ready && !redirect_valid, wrapping 2^32-1 -> 0.
REQ-028 pc+4 SHALL be computed modulo 2^32; the range check precedes any wrap.
REQ-029 A redirect to a misaligned redirect_pc SHALL be accepted, then faulted per REQ-024 on the next advance.

Reset
REQ-030 While rst_n=0: pc=RESET_PC, id_valid=0, id_pc=0, id_instr=0, id_pc_plus4=0, fetch_fault=0, fetch_count=0, state=BOOT; applied asynchronously.
REQ-031 Reset asserted mid-stall, mid-redirect or in FAULT SHALL discard all in-flight state; no partial handshake SHALL be visible after release.

Verification
REQ-032 Reset release, id_ready=1, program {0x0:00000000, 0x4:00400093, 0x8:00100113} -> id_valid rises cycle 2; id_pc sequence 0,4,8; id_instr sequence 00000000, 00400093, 00100113; fetch_count=3 after three accepts.
REQ-033 id_valid=1, id_pc=4, id_ready low for 3 cycles -> id_pc=4, id_instr=00400093, imem_pc=8 constant; fetch_count unchanged; id_pc=8 the cycle after id_ready returns.
REQ-034 redirect_valid=1, redirect_pc=36 with id_ready=0 -> next cycle id_valid=0, imem_pc=36; following cycle id_pc=36, id_instr=4010e433.
REQ-035 redirect_pc=0x26 -> fetch_fault=1 one cycle later, id_valid=0, imem_pc=0x26; a later redirect to 0 is ignored; only rst_n clears it.
REQ-036 Redirect to 1020 -> word at 1020 is delivered with id_pc_plus4=1024; next advance at pc=1024 sets fetch_fault=1.
REQ-037 rst_n pulsed low during a stall at id_pc=8 -> all outputs immediately reset values; after release id_pc=0 delivered first.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register with a valid/ready
// handshake, redirect handling and a sticky fault on misaligned or out-of-range fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_SIZE - 4);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        legal;
  logic        advance;

  // Range check is on the unwrapped PC, so a wrap of pc+4 can never look legal.
  assign legal   = (pc[1:0] == 2'b00) && (pc <= PC_MAX);
  assign advance = !id_valid || id_ready;
  assign imem_pc = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A word leaves the IF/ID register only when decode takes it and no flush hits it.
      if (id_valid && id_ready && !redirect_valid)
        fetch_count <= fetch_count + 32'd1;

      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
          end else if (advance) begin
            if (legal) begin
              id_instr    <= imem_instr;
              id_pc       <= pc;
              id_pc_plus4 <= pc + 32'd4;
              id_valid    <= 1'b1;
              pc          <= pc + 32'd4;
            end else begin
              id_valid    <= 1'b0;
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end
          end
        end
        FAULT: begin
          id_valid    <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule
